// File: rtl/dmem_banked_if.sv
// rtl/dmem_banked_if.sv - request/response bundle for the banked data memory
interface dmem_banked_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_banked.sv
// rtl/dmem_banked.sv - byte-banked single-port data memory with registered read
module dmem_banked #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         rst,
    dmem_banked_if.slave bus,
    output logic         init_done
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CLR_W = (IDX_W + 1 > 10) ? IDX_W + 1 : 10;

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;
    localparam logic [0:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;

    logic [0:0]       state;
    logic [CLR_W-1:0] clr_idx;
    logic             clr_we;

    logic [OFF-1:0]    lane_off;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        addr_lo;
    logic              size_legal;
    logic              aligned;
    logic              legal;
    logic              accept;
    logic [LANES-1:0]  size_mask;
    logic [LANES-1:0]  lane_mask;
    logic [LANES-1:0]  wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_word;

    logic              resp_valid_q;
    logic              resp_err_q;
    logic              resp_load_q;
    logic [OFF-1:0]    off_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;
    logic              sbit;
    int                nb;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[ADDR_W-1:OFF+IDX_W];

    // ---------------------------------------------------------------
    // Sweep / run control
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_RESET;
            clr_idx   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == CLR_W'(DEPTH - 1)) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: init_done <= 1'b1;
            endcase
        end
    end

    assign clr_we        = (state == S_INIT);
    assign bus.req_ready = (state == S_RUN) && init_done;
    assign accept        = bus.req_valid && bus.req_ready;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    assign lane_off = bus.req_addr[OFF-1:0];
    assign idx      = bus.req_addr[OFF+IDX_W-1:OFF];
    assign addr_lo  = bus.req_addr[2:0];

    // dword is only a real size when the word itself is 64 bits wide
    assign size_legal = (DATA_W == 64) || (bus.req_size != 2'b11);

    always_comb begin
        aligned = 1'b1;
        case (bus.req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = (addr_lo[0] == 1'b0);
            2'b10:   aligned = (addr_lo[1:0] == 2'b00);
            default: aligned = (addr_lo == 3'b000);
        endcase
    end

    assign legal = size_legal && aligned;

    always_comb begin
        size_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            size_mask[l] = (l < (1 << bus.req_size));
        end
    end

    assign lane_mask = size_mask << lane_off;
    assign wdata_sh  = bus.req_wdata << {lane_off, 3'b000};
    assign wr_en     = (accept && bus.req_we && legal) ? lane_mask : '0;
    assign rd_en     = accept && !bus.req_we && legal;

    // ---------------------------------------------------------------
    // Byte banks: sweep writes win; otherwise the request's lanes
    // ---------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (clr_we) begin
                mem[clr_idx[IDX_W-1:0]] <= 8'h00;
            end else if (wr_en[l]) begin
                mem[idx] <= wdata_sh[8*l +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rd_en) begin
                rd_q <= mem[idx];
            end
        end

        assign rd_word[8*l +: 8] = rd_q;
    end

    // ---------------------------------------------------------------
    // Response pipeline
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_load_q  <= 1'b0;
            off_q        <= '0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            resp_err_q   <= accept && !legal;
            resp_load_q  <= rd_en;
            if (accept) begin
                off_q  <= lane_off;
                size_q <= bus.req_size;
                sgn_q  <= bus.req_signed;
            end
        end
    end

    assign shifted = rd_word >> {off_q, 3'b000};

    always_comb begin
        nb = 8 << size_q;
        if (nb > DATA_W) begin
            nb = DATA_W;
        end
        case (size_q)
            2'b00:   sbit = shifted[7];
            2'b01:   sbit = shifted[15];
            2'b10:   sbit = shifted[31];
            default: sbit = shifted[DATA_W-1];
        endcase
        ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < nb) ? shifted[i] : (sgn_q & sbit);
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_load_q ? ext : '0;
endmodule

// File: tb/tb_dmem_banked.sv
// tb/tb_dmem_banked.sv - directed self-checking bench for dmem_banked
module tb_dmem_banked;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32, rst64;
    logic init_done32, init_done64;

    dmem_banked_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    dmem_banked_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    dmem_banked #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .CLEAR_ON_RESET(1)) u_dut32 (
        .clk(clk), .rst(rst32), .bus(bus32), .init_done(init_done32)
    );
    dmem_banked #(.DATA_W(64), .ADDR_W(32), .DEPTH(16), .CLEAR_ON_RESET(0)) u_dut64 (
        .clk(clk), .rst(rst64), .bus(bus64), .init_done(init_done64)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle32();
        bus32.req_valid = 0; bus32.req_we = 0; bus32.req_addr = 0;
        bus32.req_size = 0; bus32.req_signed = 0; bus32.req_wdata = 0;
    endtask

    task automatic idle64();
        bus64.req_valid = 0; bus64.req_we = 0; bus64.req_addr = 0;
        bus64.req_size = 0; bus64.req_signed = 0; bus64.req_wdata = 0;
    endtask

    task automatic acc32(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata,
                         output logic vld, output logic err, output logic [31:0] rdata);
        @(negedge clk);
        bus32.req_valid = 1; bus32.req_we = we; bus32.req_addr = addr;
        bus32.req_size = size; bus32.req_signed = sgn; bus32.req_wdata = wdata;
        @(negedge clk);
        vld = bus32.resp_valid; err = bus32.resp_err; rdata = bus32.resp_rdata;
        idle32();
    endtask

    task automatic acc64(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata,
                         output logic vld, output logic err, output logic [63:0] rdata);
        @(negedge clk);
        bus64.req_valid = 1; bus64.req_we = we; bus64.req_addr = addr;
        bus64.req_size = size; bus64.req_signed = sgn; bus64.req_wdata = wdata;
        @(negedge clk);
        vld = bus64.resp_valid; err = bus64.resp_err; rdata = bus64.resp_rdata;
        idle64();
    endtask

    task automatic xfer32(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata);
        logic v, e;
        logic [31:0] d;
        acc32(we, addr, size, sgn, wdata, v, e, d);
        check({tag, ".valid"}, 64'(v), 64'd1);
        check({tag, ".err"}, 64'(e), 64'(exp_err));
        check({tag, ".rdata"}, 64'(d), 64'(exp_rdata));
    endtask

    task automatic xfer64(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [63:0] wdata,
                          input logic exp_err, input logic [63:0] exp_rdata);
        logic v, e;
        logic [63:0] d;
        acc64(we, addr, size, sgn, wdata, v, e, d);
        check({tag, ".valid"}, 64'(v), 64'd1);
        check({tag, ".err"}, 64'(e), 64'(exp_err));
        check({tag, ".rdata"}, d, exp_rdata);
    endtask

    task automatic sweep_check32(input string tag);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) begin
                check({tag, ".init_done@15"}, 64'(init_done32), 64'd0);
                check({tag, ".ready@15"}, 64'(bus32.req_ready), 64'd0);
            end
            if (i == 16) begin
                check({tag, ".init_done@16"}, 64'(init_done32), 64'd1);
                check({tag, ".ready@16"}, 64'(bus32.req_ready), 64'd1);
            end
        end
    endtask

    logic [31:0] t2_s [4] = '{32'hFFFFFFD4, 32'hFFFFFFC3, 32'hFFFFFFB2, 32'hFFFFFFA1};
    logic [31:0] t2_u [4] = '{32'h000000D4, 32'h000000C3, 32'h000000B2, 32'h000000A1};
    logic [63:0] t6_s [8] = '{64'h18, 64'h07, 64'hFFFFFFFFFFFFFFF6, 64'hFFFFFFFFFFFFFFE5,
                              64'hFFFFFFFFFFFFFFD4, 64'hFFFFFFFFFFFFFFC3,
                              64'hFFFFFFFFFFFFFFB2, 64'hFFFFFFFFFFFFFFA1};
    logic [63:0] t6_u [8] = '{64'h18, 64'h07, 64'hF6, 64'hE5, 64'hD4, 64'hC3, 64'hB2, 64'hA1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst32 = 0; rst64 = 0;
        idle32(); idle64();
        repeat (3) @(negedge clk);

        // T1: reset values, then the zero-fill sweep timing and contents
        check("rst.ready32", 64'(bus32.req_ready), 64'd0);
        check("rst.resp_valid32", 64'(bus32.resp_valid), 64'd0);
        check("rst.resp_err32", 64'(bus32.resp_err), 64'd0);
        check("rst.rdata32", 64'(bus32.resp_rdata), 64'd0);
        check("rst.init_done32", 64'(init_done32), 64'd0);
        check("rst.ready64", 64'(bus64.req_ready), 64'd0);
        check("rst.init_done64", 64'(init_done64), 64'd0);
        rst32 = 1; rst64 = 1;
        @(posedge clk);
        #1;
        check("t1.init_done64@1", 64'(init_done64), 64'd1);
        check("t1.ready64@1", 64'(bus64.req_ready), 64'd1);
        for (int i = 2; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) check("t1.init_done32@15", 64'(init_done32), 64'd0);
            if (i == 16) begin
                check("t1.init_done32@16", 64'(init_done32), 64'd1);
                check("t1.ready32@16", 64'(bus32.req_ready), 64'd1);
            end
        end
        for (int w = 0; w < 16; w++)
            xfer32($sformatf("t1.zero[%0d]", w), 0, 32'(w * 4), 2'b10, 0, 0, 0, 32'h0);

        // T2: byte loads of a stored word, both extensions, and address aliasing
        xfer32("t2.st", 1, 32'h8, 2'b10, 0, 32'hA1B2C3D4, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            xfer32($sformatf("t2.lbs[%0d]", i), 0, 32'(8 + i), 2'b00, 1, 0, 0, t2_s[i]);
            xfer32($sformatf("t2.lbu[%0d]", i), 0, 32'(8 + i), 2'b00, 0, 0, 0, t2_u[i]);
        end
        xfer32("t2.alias", 0, 32'h48, 2'b10, 0, 0, 0, 32'hA1B2C3D4);

        // T3: sub-word stores leave neighbouring lanes untouched
        xfer32("t3.stw", 1, 32'h4, 2'b10, 0, 32'h11223344, 0, 32'h0);
        xfer32("t3.sth", 1, 32'h6, 2'b01, 0, 32'h00008001, 0, 32'h0);
        xfer32("t3.lw", 0, 32'h4, 2'b10, 0, 0, 0, 32'h80013344);
        xfer32("t3.lhs", 0, 32'h6, 2'b01, 1, 0, 0, 32'hFFFF8001);
        xfer32("t3.lhu", 0, 32'h4, 2'b01, 0, 0, 0, 32'h00003344);
        xfer32("t3.stb", 1, 32'h5, 2'b00, 0, 32'h000000AB, 0, 32'h0);
        xfer32("t3.lw2", 0, 32'h4, 2'b10, 0, 0, 0, 32'h8001AB44);
        xfer32("t3.lbs", 0, 32'h5, 2'b00, 1, 0, 0, 32'hFFFFFFAB);

        // T4: misaligned and illegal-size requests error out without writing
        xfer32("t4.stw", 1, 32'h0, 2'b10, 0, 32'h55667788, 0, 32'h0);
        xfer32("t4.lh3", 0, 32'h3, 2'b01, 1, 0, 1, 32'h0);
        xfer32("t4.sw2", 1, 32'h2, 2'b10, 0, 32'hDEADBEEF, 1, 32'h0);
        xfer32("t4.sd", 1, 32'h0, 2'b11, 0, 32'hDEADBEEF, 1, 32'h0);
        xfer32("t4.ld", 0, 32'h0, 2'b11, 0, 0, 1, 32'h0);
        xfer32("t4.reread", 0, 32'h0, 2'b10, 0, 0, 0, 32'h55667788);
        xfer32("t4.lh2", 0, 32'h2, 2'b01, 0, 0, 0, 32'h00005566);

        // T5: back-to-back store then load of the same word
        @(negedge clk);
        bus32.req_valid = 1; bus32.req_we = 1; bus32.req_addr = 32'h10;
        bus32.req_size = 2'b10; bus32.req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("t5.st.valid", 64'(bus32.resp_valid), 64'd1);
        check("t5.st.err", 64'(bus32.resp_err), 64'd0);
        bus32.req_we = 0; bus32.req_wdata = 0;
        @(negedge clk);
        check("t5.ld.valid", 64'(bus32.resp_valid), 64'd1);
        check("t5.ld.rdata", 64'(bus32.resp_rdata), 64'hCAFEF00D);
        idle32();
        @(negedge clk);
        check("t5.idle.valid", 64'(bus32.resp_valid), 64'd0);

        // T6: reset mid-sweep restarts it; reset drops an in-flight load
        xfer32("t6.st", 1, 32'h3C, 2'b10, 0, 32'h12345678, 0, 32'h0);
        xfer32("t6.ld", 0, 32'h3C, 2'b10, 0, 0, 0, 32'h12345678);
        @(negedge clk); rst32 = 0;
        @(negedge clk); rst32 = 1;
        repeat (5) @(posedge clk);
        @(negedge clk); rst32 = 0;
        @(negedge clk); rst32 = 1;
        sweep_check32("t6.restart");
        xfer32("t6.cleared", 0, 32'h3C, 2'b10, 0, 0, 0, 32'h0);
        xfer32("t6.st2", 1, 32'h3C, 2'b10, 0, 32'h0BADF00D, 0, 32'h0);
        @(negedge clk);
        bus32.req_valid = 1; bus32.req_addr = 32'h3C; bus32.req_size = 2'b10;
        rst32 = 0;
        @(negedge clk);
        check("t6.dropped.valid", 64'(bus32.resp_valid), 64'd0);
        check("t6.dropped.ready", 64'(bus32.req_ready), 64'd0);
        idle32();
        rst32 = 1;
        k = 0;
        while (!init_done32 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t6.reinit", 64'(init_done32), 64'd1);
        xfer32("t6.after", 0, 32'h3C, 2'b10, 0, 0, 0, 32'h0);

        // T6 on the 64-bit instance: dword store, byte/half/word/dword loads
        xfer64("t6w.st", 1, 32'h8, 2'b11, 0, 64'hA1B2C3D4E5F60718, 0, 64'h0);
        for (int i = 0; i < 8; i++) begin
            xfer64($sformatf("t6w.lbs[%0d]", i), 0, 32'(8 + i), 2'b00, 1, 0, 0, t6_s[i]);
            xfer64($sformatf("t6w.lbu[%0d]", i), 0, 32'(8 + i), 2'b00, 0, 0, 0, t6_u[i]);
        end
        xfer64("t6w.ld", 0, 32'h8, 2'b11, 1, 0, 0, 64'hA1B2C3D4E5F60718);
        xfer64("t6w.alias", 0, 32'h88, 2'b11, 0, 0, 0, 64'hA1B2C3D4E5F60718);
        xfer64("t6w.lws", 0, 32'hC, 2'b10, 1, 0, 0, 64'hFFFFFFFFA1B2C3D4);
        xfer64("t6w.lwu", 0, 32'h8, 2'b10, 0, 0, 0, 64'h00000000E5F60718);
        xfer64("t6w.lhs", 0, 32'hE, 2'b01, 1, 0, 0, 64'hFFFFFFFFFFFFA1B2);
        xfer64("t6w.mis", 0, 32'h4, 2'b11, 0, 0, 1, 64'h0);
        xfer64("t6w.stb", 1, 32'hF, 2'b00, 0, 64'h5A, 0, 64'h0);
        xfer64("t6w.ld2", 0, 32'h8, 2'b11, 0, 0, 0, 64'h5AB2C3D4E5F60718);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
